mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
Sequencer that builds an OPW x OPW multiply from the existing combinational 4x4 nibble multiplier (8 operand bits in, 8 result bits out).
- Latches operands on a start handshake.
- Steps nibble-pair partial products through the shared 4x4 multiplier, one per cycle.
- Accumulates them shifted, then presents the 2*OPW product with a done pulse.
- The 4x4 multiplier stays a separate instance; this block only drives its inputs and reads its result.

Parameters:
- OPW, 8, operand width in bits; must be a multiple of 4, range 4..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a multiply; accepted only when the FSM is in IDLE or DONE.
- a  in  OPW  multiplicand; sampled on the accepting edge.
- b  in  OPW  multiplier; sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; p is valid from this cycle.
- p  out  2*OPW  product; held until the next accepted start.
- mul_a  out  4  nibble to 4x4 multiplier A0..A3.
- mul_b  out  4  nibble to 4x4 multiplier B0..B3.
- mul_r  in  8  4x4 multiplier result R0..R7 (combinational, same cycle).

Behaviour:
- Clocking and reset:
  - Single clock domain (clk); reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
  - Reset values: FSM=IDLE, busy=0, done=0, p=0, accumulator=0, step=0, mul_a=0, mul_b=0.
- Constants: K = OPW/4 and N = K*K steps (OPW=8: K=2, N=4).
- FSM states IDLE, RUN, DONE:
  - IDLE: mul_a=mul_b=0. On start=1: latch a and b, clear the accumulator, step=0, go to RUN.
  - RUN: ai = step mod K, bi = step div K.
    - mul_a = a_lat[4*ai+3:4*ai], mul_b = b_lat[4*bi+3:4*bi].
    - Each edge: acc <= acc + (mul_r zero-extended to 2*OPW) << 4*(ai+bi), modulo 2^(2*OPW); step++.
    - After the step N-1 accumulation, go to DONE.
  - DONE: p <= final accumulated value (registered on entry); done=1 for exactly this cycle.
    - start=1 here is accepted (back-to-back), goes to RUN, with operands latched as in IDLE.
    - Otherwise go to IDLE.
- Latency: start accepted at edge T; done=1 and p valid in the cycle after edge T+N (OPW=8: 5 cycles). Sustained throughput is one product per N+1 cycles.
- start while in RUN is ignored: no queuing, operands unchanged.
- a and b may change freely after the accepting edge.
- p is stable outside the DONE-entry edge and is never partially updated.
- rst mid-RUN aborts immediately: all registers return to reset values and no done pulse is produced.
- No overflow is possible: the full 2*OPW width holds OPW x OPW.

Optional Feature:
- Macro: MUL_SEQ_SIGNED_EN.
- Defined: a and b are two's complement.
  - On accept, latch their magnitudes (|-2^(OPW-1)| = 2^(OPW-1) fits unsigned OPW) and sign s = a[MSB]^b[MSB].
  - In DONE, p = s ? -acc : acc (2*OPW two's complement).
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Package mul_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - NIB=4;
  - MUL_R_W=8;
  - a function computing N from OPW.
- No sub-module. The 4x4 multiplier is instantiated beside this block by the parent and wired mul_a/mul_b/mul_r.
- The bench instantiates the pair together.

Test Plan:
- Basic product, OPW=8 unsigned: a=0x12, b=0x34, start pulse -> busy for 4 cycles; done in the 5th cycle after accept; p=0x03A8; p holds until next start.
- Max operands: a=0xFF, b=0xFF -> p=0xFE01. Zero case: a=0x00, b=0xA5 -> p=0x0000.
- Back-to-back: hold start=1 with a=0x0F, b=0x10, then a=0x80, b=0x02 on the done cycle -> two done pulses 5 cycles apart; p=0x00F0 then 0x0100.
- Start ignored mid-RUN: a=0x12, b=0x34 accepted; start with a=0xFF, b=0xFF two cycles later -> single done, p=0x03A8.
- Reset mid-RUN: rst at the 2nd RUN cycle -> next cycle busy=0, done=0, p=0; no done pulse afterwards; a new start with 0x03 x 0x05 -> p=0x000F.
- MUL_SEQ_SIGNED_EN defined:
  - 0xFF x 0xFF -> p=0x0001.
  - 0x80 x 0x7F -> p=0xC080.
  - 0x80 x 0x80 -> p=0x4000.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// ============================================================================
// Module : mul_seq_pkg
// Brief  : Shared types and constants for the nibble-sequenced multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB     = 4;
    localparam int MUL_R_W = 8;

    // One partial product per nibble pair of the two operands.
    function automatic int mul_seq_steps(input int opw);
        return (opw / NIB) * (opw / NIB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module : mul_seq_ctrl
// Brief  : Sequences an OPW x OPW multiply through an external 4x4 multiplier.
//          Define MUL_SEQ_SIGNED_EN for two's-complement operands.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int OPW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OPW-1:0]       a,
    input  logic [OPW-1:0]       b,
    output logic                 busy,
    output logic                 done,
    output logic [2*OPW-1:0]     p,
    output logic [NIB-1:0]       mul_a,
    output logic [NIB-1:0]       mul_b,
    input  logic [MUL_R_W-1:0]   mul_r
);

    localparam int K      = OPW / NIB;
    localparam int N      = mul_seq_steps(OPW);
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW     = 2 * OPW;

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         p_q, p_d;
    logic [OPW-1:0]        a_lat_q, a_lat_d;
    logic [OPW-1:0]        b_lat_q, b_lat_d;

    logic [STEP_W-1:0]     ai, bi;
    logic [PW-1:0]         partial;
    logic [PW-1:0]         acc_sum;
    logic [OPW-1:0]        a_mag, b_mag;
    logic [PW-1:0]         final_val;

`ifdef MUL_SEQ_SIGNED_EN
    logic                  sign_q, sign_d;

    // Magnitudes of the most negative value still fit in OPW unsigned bits.
    always_comb begin
        a_mag     = a[OPW-1] ? -a : a;
        b_mag     = b[OPW-1] ? -b : b;
        final_val = sign_q ? -acc_sum : acc_sum;
    end
`else
    always_comb begin
        a_mag     = a;
        b_mag     = b;
        final_val = acc_sum;
    end
`endif

    assign ai      = STEP_W'(int'(step_q) % K);
    assign bi      = STEP_W'(int'(step_q) / K);
    assign partial = PW'(mul_r) << (NIB * (int'(ai) + int'(bi)));
    assign acc_sum = acc_q + partial;
    assign p       = p_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        p_d     = p_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
`ifdef MUL_SEQ_SIGNED_EN
        sign_d  = sign_q;
`endif
        mul_a   = '0;
        mul_b   = '0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    a_lat_d = a_mag;
                    b_lat_d = b_mag;
`ifdef MUL_SEQ_SIGNED_EN
                    sign_d  = a[OPW-1] ^ b[OPW-1];
`endif
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                mul_a  = a_lat_q[NIB*ai +: NIB];
                mul_b  = b_lat_q[NIB*bi +: NIB];
                acc_d  = acc_sum;
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(N - 1)) begin
                    // p is loaded in one shot so it never shows a partial sum.
                    p_d     = final_val;
                    step_d  = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            a_lat_q <= '0;
            b_lat_q <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            a_lat_q <= a_lat_d;
            b_lat_q <= b_lat_d;
`ifdef MUL_SEQ_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

endmodule

`default_nettype wire
